updown_seq_ctrl: RTL and testbench

//  Sequencer for the T-flip-flop up/down counter datapath. It owns a WIDTH-bit
//  up/down count register and steps it one position at a time toward a

---
 rtl/updown_seq_ctrl.sv | 135 +++++++++++++
 tb/tb_updown_seq_ctrl.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/updown_seq_ctrl.sv
// updown_seq_ctrl: walks a WIDTH-bit up/down count register one step at a
// time toward a requested target, on the falling edge of clk. The direction
// is either the shortest modular path or the one the requester forces.
// busy/done/step report progress, and abort ends a run early.
// force_en carries the force-direction request. "force" is a reserved word
// in SystemVerilog, so it cannot be used as a port name.
module updown_seq_ctrl #(
   parameter int WIDTH = 4,
   parameter int HOLD  = 1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [WIDTH-1:0] target,
   input  logic             force_en,
   input  logic             x_force,
   input  logic             abort,
   output logic [WIDTH-1:0] Q,
   output logic             x,
   output logic             step,
   output logic             busy,
   output logic             done
);

   localparam int             HW          = (HOLD > 1) ? $clog2(HOLD) : 1;
   localparam logic [HW-1:0]  HOLD_RELOAD = HW'(HOLD - 1);

   typedef enum logic [1:0] {S_IDLE, S_ARM, S_RUN, S_DONE} state_t;

   state_t           state_q, state_d;
   logic [WIDTH-1:0] q_q, q_d;
   logic             x_q, x_d;
   logic             step_q, step_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic [HW-1:0]    hold_q, hold_d;
   logic [WIDTH-1:0] tgt_q, tgt_d;
   logic             frc_q, frc_d;
   logic             xf_q, xf_d;
   logic [WIDTH-1:0] up_dist, dn_dist;

   // Next-state logic: request capture, direction choice, stepping, abort.
   always_comb begin
      state_d = state_q;
      q_d     = q_q;
      x_d     = x_q;
      hold_d  = hold_q;
      tgt_d   = tgt_q;
      frc_d   = frc_q;
      xf_d    = xf_q;
      step_d  = 1'b0;
      up_dist = tgt_q - q_q;
      dn_dist = q_q - tgt_q;
      case (state_q)
         S_IDLE: begin
            // abort wins over start while idle
            if (start && !abort) begin
               tgt_d   = target;
               frc_d   = force_en;
               xf_d    = x_force;
               state_d = S_ARM;
            end
         end
         S_ARM: begin
            if (abort) begin
               state_d = S_IDLE;
            end else begin
               // a tie between the two modular distances goes up
               x_d = frc_q ? xf_q : ((up_dist <= dn_dist) ? 1'b0 : 1'b1);
               if (tgt_q == q_q) begin
                  state_d = S_DONE;
               end else begin
                  hold_d  = HOLD_RELOAD;
                  state_d = S_RUN;
               end
            end
         end
         S_RUN: begin
            if (abort) begin
               state_d = S_IDLE;
            end else if (hold_q != '0) begin
               hold_d = hold_q - HW'(1);
            end else begin
               q_d    = x_q ? (q_q - WIDTH'(1)) : (q_q + WIDTH'(1));
               step_d = 1'b1;
               hold_d = HOLD_RELOAD;
               if (q_d == tgt_q) state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
      busy_d = (state_d == S_ARM) || (state_d == S_RUN);
      done_d = (state_d == S_DONE);
   end

   // Control and count registers, asynchronously cleared.
   always_ff @(negedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         q_q     <= '0;
         x_q     <= 1'b0;
         step_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         hold_q  <= '0;
      end else begin
         state_q <= state_d;
         q_q     <= q_d;
         x_q     <= x_d;
         step_q  <= step_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         hold_q  <= hold_d;
      end
   end

   // Latched request; only meaningful once a start has been accepted.
   always_ff @(negedge clk) begin
      tgt_q <= tgt_d;
      frc_q <= frc_d;
      xf_q  <= xf_d;
   end

   assign Q    = q_q;
   assign x    = x_q;
   assign step = step_q;
   assign busy = busy_q;
   assign done = done_q;

endmodule

// File: tb/tb_updown_seq_ctrl.sv
// Bench for updown_seq_ctrl: a vector table of runs checked cycle by cycle
// through an expected-output queue, plus hand sequences for reset, abort
// and the multi-cycle HOLD case.
module tb_updown_seq_ctrl;

   logic       clk = 1'b0;
   logic       rst;
   logic       start, force_en, x_force, abort;
   logic [3:0] target;
   logic [3:0] Q;
   logic       x, step, busy, done;
   logic       s3_start, s3_force, s3_xf, s3_abort;
   logic [3:0] s3_target;
   logic [3:0] s3_q;
   logic       s3_x, s3_step, s3_busy, s3_done;

   always #5 clk = ~clk;

   updown_seq_ctrl #(.WIDTH(4), .HOLD(1)) u1 (
      .clk(clk), .rst(rst), .start(start), .target(target), .force_en(force_en),
      .x_force(x_force), .abort(abort), .Q(Q), .x(x), .step(step), .busy(busy),
      .done(done));

   updown_seq_ctrl #(.WIDTH(4), .HOLD(3)) u3 (
      .clk(clk), .rst(rst), .start(s3_start), .target(s3_target), .force_en(s3_force),
      .x_force(s3_xf), .abort(s3_abort), .Q(s3_q), .x(s3_x), .step(s3_step),
      .busy(s3_busy), .done(s3_done));

   typedef struct {
      logic [3:0] tgt;
      logic       frc;
      logic       xf;
      logic       noise;
      logic       exp_x;
      int         exp_k;
   } vec_t;

   typedef struct {
      logic [3:0] q;
      logic       step;
      logic       busy;
      logic       done;
      logic       x;
   } exp_t;

   exp_t       sbq[$];
   vec_t       vecs[14];
   int         checks = 0;
   int         errors = 0;
   logic [3:0] cur_q;
   logic       cur_x;

   task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h exp %0h", name, got, exp);
      end
   endtask

   // sample point sits 2 time units after the falling (active) edge
   task automatic sample();
      @(negedge clk);
      #2;
   endtask

   task automatic run_vec(input int idx, input vec_t v);
      exp_t       e;
      logic [3:0] qn;
      int         n;
      start    = 1'b1;
      target   = v.tgt;
      force_en = v.frc;
      x_force  = v.xf;
      e.q = cur_q; e.step = 1'b0; e.busy = 1'b1; e.done = 1'b0; e.x = cur_x;
      sbq.push_back(e);
      e.busy = (v.exp_k != 0); e.done = (v.exp_k == 0); e.x = v.exp_x;
      sbq.push_back(e);
      qn = cur_q;
      for (int i = 1; i <= v.exp_k; i++) begin
         qn = v.exp_x ? (qn - 4'd1) : (qn + 4'd1);
         e.q = qn; e.step = 1'b1; e.busy = (i < v.exp_k); e.done = (i == v.exp_k);
         sbq.push_back(e);
      end
      e.step = 1'b0; e.busy = 1'b0; e.done = 1'b0;
      sbq.push_back(e);
      n = 0;
      while (sbq.size() > 0) begin
         sample();
         e = sbq.pop_front();
         chk($sformatf("v%0d_c%0d_q", idx, n), 8'(Q), 8'(e.q));
         chk($sformatf("v%0d_c%0d_step", idx, n), 8'(step), 8'(e.step));
         chk($sformatf("v%0d_c%0d_busy", idx, n), 8'(busy), 8'(e.busy));
         chk($sformatf("v%0d_c%0d_done", idx, n), 8'(done), 8'(e.done));
         chk($sformatf("v%0d_c%0d_x", idx, n), 8'(x), 8'(e.x));
         if (v.noise && sbq.size() > 1) begin
            start    = 1'b1;
            target   = ~v.tgt;
            force_en = ~v.frc;
            x_force  = ~v.xf;
         end else begin
            start    = 1'b0;
            target   = v.tgt;
            force_en = v.frc;
            x_force  = v.xf;
         end
         n++;
      end
      start = 1'b0;
      cur_q = qn;
      cur_x = v.exp_x;
   endtask

   initial begin
      // {target, force, x_force, noise, expected x, expected step count}
      vecs[0]  = '{4'd9,  1'b1, 1'b0, 1'b1, 1'b0, 6};
      vecs[1]  = '{4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 7};
      vecs[2]  = '{4'd5,  1'b0, 1'b0, 1'b0, 1'b0, 5};
      vecs[3]  = '{4'd1,  1'b0, 1'b0, 1'b0, 1'b1, 4};
      vecs[4]  = '{4'd14, 1'b0, 1'b0, 1'b0, 1'b1, 3};
      vecs[5]  = '{4'd1,  1'b1, 1'b0, 1'b0, 1'b0, 3};
      vecs[6]  = '{4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 5};
      vecs[7]  = '{4'd6,  1'b1, 1'b1, 1'b0, 1'b1, 0};
      vecs[8]  = '{4'd6,  1'b0, 1'b0, 1'b0, 1'b0, 0};
      vecs[9]  = '{4'd0,  1'b1, 1'b0, 1'b0, 1'b0, 10};
      vecs[10] = '{4'd8,  1'b0, 1'b0, 1'b0, 1'b0, 8};
      vecs[11] = '{4'd0,  1'b0, 1'b0, 1'b0, 1'b0, 8};
      vecs[12] = '{4'd1,  1'b1, 1'b1, 1'b0, 1'b1, 15};
      vecs[13] = '{4'd0,  1'b0, 1'b0, 1'b0, 1'b1, 1};

      rst = 1'b1; start = 1'b0; target = 4'd0; force_en = 1'b0; x_force = 1'b0; abort = 1'b0;
      s3_start = 1'b0; s3_target = 4'd0; s3_force = 1'b0; s3_xf = 1'b0; s3_abort = 1'b0;

      // reset state
      sample();
      chk("rst_q", 8'(Q), 8'd0);
      chk("rst_busy", 8'(busy), 8'd0);
      chk("rst_done", 8'(done), 8'd0);
      chk("rst_step", 8'(step), 8'd0);
      chk("rst_x", 8'(x), 8'd0);
      sample();
      rst = 1'b0;

      // asynchronous reset in the middle of a run at Q=3
      start = 1'b1; target = 4'd9; force_en = 1'b1; x_force = 1'b0;
      sample();
      start = 1'b0;
      sample();
      sample();
      sample();
      sample();
      chk("mid_q3", 8'(Q), 8'd3);
      chk("mid_step", 8'(step), 8'd1);
      chk("mid_busy", 8'(busy), 8'd1);
      #1 rst = 1'b1;
      #1;
      chk("arst_q", 8'(Q), 8'd0);
      chk("arst_busy", 8'(busy), 8'd0);
      chk("arst_done", 8'(done), 8'd0);
      chk("arst_step", 8'(step), 8'd0);
      sample();
      rst = 1'b0;
      sample();
      chk("post_rst_q", 8'(Q), 8'd0);
      chk("post_rst_busy", 8'(busy), 8'd0);

      // abort at Q=3 during a 0 -> 9 run
      start = 1'b1; target = 4'd9; force_en = 1'b1; x_force = 1'b0;
      sample();
      start = 1'b0;
      sample();
      sample();
      sample();
      sample();
      chk("pre_abort_q", 8'(Q), 8'd3);
      chk("pre_abort_busy", 8'(busy), 8'd1);
      abort = 1'b1;
      sample();
      chk("abort_q", 8'(Q), 8'd3);
      chk("abort_step", 8'(step), 8'd0);
      chk("abort_busy", 8'(busy), 8'd0);
      chk("abort_done", 8'(done), 8'd0);
      sample();
      chk("abort_idle_q", 8'(Q), 8'd3);
      chk("abort_idle_done", 8'(done), 8'd0);
      chk("abort_idle_busy", 8'(busy), 8'd0);
      abort = 1'b0;
      cur_q = 4'd3;
      cur_x = 1'b0;

      // table of runs; the first one also carries ignored mid-run requests
      for (int i = 0; i < 14; i++) run_vec(i, vecs[i]);

      // abort beats start while idle
      start = 1'b1; abort = 1'b1; target = 4'd5; force_en = 1'b0;
      sample();
      chk("abs_busy", 8'(busy), 8'd0);
      chk("abs_q", 8'(Q), 8'd0);
      sample();
      chk("abs_busy2", 8'(busy), 8'd0);
      start = 1'b0; abort = 1'b0;
      sample();
      chk("abs_q2", 8'(Q), 8'd0);
      chk("abs_busy3", 8'(busy), 8'd0);

      // HOLD=3: Q changes only at edges n+4 and n+7
      s3_start = 1'b1; s3_target = 4'd2; s3_force = 1'b0; s3_xf = 1'b0;
      for (int i = 0; i < 9; i++) begin
         sample();
         if (i == 0) s3_start = 1'b0;
         chk($sformatf("h3_c%0d_q", i), 8'(s3_q), (i >= 7) ? 8'd2 : ((i >= 4) ? 8'd1 : 8'd0));
         chk($sformatf("h3_c%0d_step", i), 8'(s3_step), (i == 4 || i == 7) ? 8'd1 : 8'd0);
         chk($sformatf("h3_c%0d_busy", i), 8'(s3_busy), (i < 7) ? 8'd1 : 8'd0);
         chk($sformatf("h3_c%0d_done", i), 8'(s3_done), (i == 7) ? 8'd1 : 8'd0);
         chk($sformatf("h3_c%0d_x", i), 8'(s3_x), 8'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
